// File: rtl/s_axi_rd.sv
`default_nettype none
// ============================================================================
// Module   : s_axi_rd
// Brief    : AXI4-Lite AR/R responder over a word-indexed local memory with
//            a side load port and configurable read latency (1..4).
// Revision : 1.0 - initial release
// ============================================================================
module s_axi_rd #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [ADDR_W-1:0]        s_axi_araddr,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [DATA_W-1:0]        s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
    input  logic [DATA_W-1:0]        i_ld_data
);

    localparam int              IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      CNT_INIT  = 2'(RD_LAT - 1);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("s_axi_rd: RD_LAT must be within 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              live_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic ar_hs;
    logic r_hs;
    logic sample;
    logic in_range;

    // live_q keeps arready low while in reset and for the first edge after it
    assign s_axi_arready = (state == IDLE) && live_q;
    assign s_axi_rvalid  = (state == RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign ar_hs    = s_axi_arvalid && s_axi_arready;
    assign r_hs     = s_axi_rvalid && s_axi_rready;
    assign sample   = (state == BUSY) && (cnt == 2'd0);
    assign in_range = {1'b0, addr_q} < DEPTH_EXT;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs)  state_nxt = BUSY;
            BUSY:    if (sample) state_nxt = RESP;
            RESP:    if (r_hs)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            live_q  <= 1'b0;
            cnt     <= 2'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            live_q <= 1'b1;
            if (ar_hs) begin
                addr_q <= s_axi_araddr;
                cnt    <= CNT_INIT;
            end else if (state == BUSY && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
            // Sampling with <= against the same-edge load gives read-before-write
            if (sample) begin
                if (in_range) begin
                    rdata_q <= mem[addr_q[IDX_W-1:0]];
                    rresp_q <= 2'b00;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= 2'b11;
                end
            end else if (r_hs) begin
                rdata_q <= '0;
                rresp_q <= 2'b00;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_ld_en) begin
            mem[i_ld_addr] <= i_ld_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s_axi_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_axi_rd
// Brief    : Directed bench for s_axi_rd; four instances cover RD_LAT=1..4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s_axi_rd;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] araddr = '0;
    logic        rready = 1'b1;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic        arvalid [1:4];
    logic        arready [1:4];
    logic        rvalid  [1:4];
    logic [31:0] rdata   [1:4];
    logic [1:0]  rresp   [1:4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        s_axi_rd #(
            .ADDR_W(32),
            .DATA_W(32),
            .DEPTH (16),
            .RD_LAT(g)
        ) u_dut (
            .i_clk        (clk),
            .i_resetn     (resetn),
            .s_axi_arvalid(arvalid[g]),
            .s_axi_arready(arready[g]),
            .s_axi_araddr (araddr),
            .s_axi_rvalid (rvalid[g]),
            .s_axi_rready (rready),
            .s_axi_rdata  (rdata[g]),
            .s_axi_rresp  (rresp[g]),
            .i_ld_en      (ld_en),
            .i_ld_addr    (ld_addr),
            .i_ld_data    (ld_data)
        );
    end

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | (i << 16) | (i * 17);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a[3:0];
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic test_reset();
        for (int l = 1; l <= 4; l++) arvalid[l] = 1'b0;
        resetn = 1'b0;
        rready = 1'b1;
        tick();
        tick();
        for (int l = 1; l <= 4; l++) begin
            n_cmp++;
            if (arready[l] !== 1'b0 || rvalid[l] !== 1'b0 || rdata[l] !== 32'h0 || rresp[l] !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_outputs lat%0d: arready=%b rvalid=%b rdata=%h rresp=%b, want all 0", l, arready[l], rvalid[l], rdata[l], rresp[l]);
            end
        end
        resetn = 1'b1;
        n_cmp++;
        if (arready[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL arready_before_edge: got %b want 0", arready[1]);
        end
        tick();
        for (int l = 1; l <= 4; l++) begin
            n_cmp++;
            if (arready[l] !== 1'b1) begin
                n_bad++;
                $display("FAIL arready_after_release lat%0d: got %b want 1", l, arready[l]);
            end
        end
    endtask

    task automatic test_basic_read();
        load(3, 32'hDEADBEEF);
        araddr = 32'd3;
        arvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0;
        n_cmp++;
        if (arready[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy: arready=%b rvalid=%b want 0 0", arready[1], rvalid[1]);
        end
        tick();
        n_cmp++;
        if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hDEADBEEF || rresp[1] !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_resp: rvalid=%b rdata=%h rresp=%b want 1 deadbeef 00", rvalid[1], rdata[1], rresp[1]);
        end
        tick();
        n_cmp++;
        if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1 || rdata[1] !== 32'h0) begin
            n_bad++;
            $display("FAIL basic_done: rvalid=%b arready=%b rdata=%h want 0 1 0", rvalid[1], arready[1], rdata[1]);
        end
    endtask

    task automatic test_decerr();
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'd16;
        bad_addr[1] = 32'hFFFF_FFF0;
        load(0, 32'h1234_5678);
        for (int k = 0; k < 2; k++) begin
            araddr = bad_addr[k];
            arvalid[1] = 1'b1;
            tick();
            arvalid[1] = 1'b0;
            n_cmp++;
            if (rvalid[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL decerr_early %h: rvalid=%b want 0", bad_addr[k], rvalid[1]);
            end
            tick();
            n_cmp++;
            if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h0 || rresp[1] !== 2'b11) begin
                n_bad++;
                $display("FAIL decerr_resp %h: rvalid=%b rdata=%h rresp=%b want 1 0 11", bad_addr[k], rvalid[1], rdata[1], rresp[1]);
            end
            tick();
            n_cmp++;
            if (rvalid[1] !== 1'b0 || rresp[1] !== 2'b00) begin
                n_bad++;
                $display("FAIL decerr_done %h: rvalid=%b rresp=%b want 0 00", bad_addr[k], rvalid[1], rresp[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        load(5, 32'h5555_5555);
        rready = 1'b0;
        araddr = 32'd3;
        arvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            araddr = 32'd5;
            arvalid[1] = (k % 2 == 0);
            tick();
            n_cmp++;
            if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hDEADBEEF || rresp[1] !== 2'b00 || arready[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold cyc%0d: rvalid=%b rdata=%h rresp=%b arready=%b want 1 deadbeef 00 0", k, rvalid[1], rdata[1], rresp[1], arready[1]);
            end
        end
        arvalid[1] = 1'b0;
        rready = 1'b1;
        tick();
        n_cmp++;
        if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: rvalid=%b arready=%b want 0 1", rvalid[1], arready[1]);
        end
        tick();
        tick();
        n_cmp++;
        if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_no_capture: rvalid=%b arready=%b want 0 1", rvalid[1], arready[1]);
        end
    endtask

    task automatic test_latency_sweep();
        int hs;
        int prev;
        for (int i = 0; i < 16; i++) load(i, pat(i));
        rready = 1'b1;
        for (int l = 1; l <= 4; l++) begin
            prev = 0;
            for (int i = 0; i < 16; i++) begin
                araddr = i;
                arvalid[l] = 1'b1;
                n_cmp++;
                if (arready[l] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep_arready lat%0d idx%0d: got %b want 1", l, i, arready[l]);
                end
                tick();
                hs = cyc;
                arvalid[l] = 1'b0;
                if (i > 0) begin
                    n_cmp++;
                    if (hs - prev !== l + 2) begin
                        n_bad++;
                        $display("FAIL sweep_period lat%0d idx%0d: got %0d want %0d", l, i, hs - prev, l + 2);
                    end
                end
                prev = hs;
                for (int k = 1; k < l; k++) begin
                    tick();
                    n_cmp++;
                    if (rvalid[l] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL sweep_early lat%0d idx%0d c%0d: rvalid=%b want 0", l, i, k, rvalid[l]);
                    end
                end
                tick();
                n_cmp++;
                if (rvalid[l] !== 1'b1 || rdata[l] !== pat(i) || rresp[l] !== 2'b00) begin
                    n_bad++;
                    $display("FAIL sweep_data lat%0d idx%0d: rvalid=%b rdata=%h rresp=%b want 1 %h 00", l, i, rvalid[l], rdata[l], rresp[l], pat(i));
                end
                tick();
            end
        end
    endtask

    task automatic test_collision();
        // Load on the sample edge itself (T0+3) must not be seen
        load(7, 32'd1);
        araddr = 32'd7;
        arvalid[3] = 1'b1;
        tick();
        arvalid[3] = 1'b0;
        tick();
        tick();
        ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'd2;
        tick();
        ld_en = 1'b0;
        n_cmp++;
        if (rvalid[3] !== 1'b1 || rdata[3] !== 32'd1) begin
            n_bad++;
            $display("FAIL collide_same_edge: rvalid=%b rdata=%h want 1 00000001", rvalid[3], rdata[3]);
        end
        tick();
        load(7, 32'd1);
        araddr = 32'd7;
        arvalid[3] = 1'b1;
        tick();
        arvalid[3] = 1'b0;
        ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'd2;
        tick();
        ld_en = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (rvalid[3] !== 1'b1 || rdata[3] !== 32'd2) begin
            n_bad++;
            $display("FAIL collide_earlier: rvalid=%b rdata=%h want 1 00000002", rvalid[3], rdata[3]);
        end
        tick();
        araddr = 32'd7;
        arvalid[1] = 1'b1;
        ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'd9;
        tick();
        arvalid[1] = 1'b0;
        ld_en = 1'b0;
        tick();
        n_cmp++;
        if (rvalid[1] !== 1'b1 || rdata[1] !== 32'd9) begin
            n_bad++;
            $display("FAIL collide_at_ar: rvalid=%b rdata=%h want 1 00000009", rvalid[1], rdata[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // Reset during BUSY on the RD_LAT=2 instance
        load(3, 32'hCAFE_F00D);
        araddr = 32'd3;
        arvalid[2] = 1'b1;
        tick();
        arvalid[2] = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (rvalid[2] !== 1'b0 || arready[2] !== 1'b0 || rdata[2] !== 32'h0 || rresp[2] !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_busy: rvalid=%b arready=%b rdata=%h rresp=%b want all 0", rvalid[2], arready[2], rdata[2], rresp[2]);
        end
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (rvalid[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_busy_no_beat c%0d: rvalid=%b want 0", k, rvalid[2]);
            end
        end
        // Reset during RESP under backpressure on the RD_LAT=1 instance
        load(3, 32'hCAFE_F00D);
        rready = 1'b0;
        araddr = 32'd3;
        arvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0;
        tick();
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (rvalid[1] !== 1'b0 || arready[1] !== 1'b0 || rdata[1] !== 32'h0 || rresp[1] !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_resp: rvalid=%b arready=%b rdata=%h rresp=%b want all 0", rvalid[1], arready[1], rdata[1], rresp[1]);
        end
        tick();
        resetn = 1'b1;
        rready = 1'b1;
        tick();
        n_cmp++;
        if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_resp_release: rvalid=%b arready=%b want 0 1", rvalid[1], arready[1]);
        end
        for (int i = 0; i < 16; i += 5) begin
            araddr = i;
            arvalid[1] = 1'b1;
            tick();
            arvalid[1] = 1'b0;
            tick();
            n_cmp++;
            if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h0 || rresp[1] !== 2'b00) begin
                n_bad++;
                $display("FAIL rst_mem_clear idx%0d: rvalid=%b rdata=%h rresp=%b want 1 0 00", i, rvalid[1], rdata[1], rresp[1]);
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_decerr();
        test_backpressure();
        test_latency_sweep();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
